// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Shared rename/retire definitions: physical register ID type,
//                register-file sizes and free-list sizing/pointer types.
//  Revision    : 1.0 - initial release
// ============================================================================
package common;

    localparam int NUM_PRF      = 64;
    localparam int NUM_ARCH     = 32;
    localparam int PRF_ID_W     = $clog2(NUM_PRF);

    typedef logic [PRF_ID_W-1:0] t_prf_id;

    // Free-list holds every register that is not architecturally mapped.
    localparam int PRF_FL_DEPTH = NUM_PRF - NUM_ARCH;
    // One extra pointer bit distinguishes full from empty.
    localparam int PRF_FL_PTR_W = $clog2(PRF_FL_DEPTH) + 1;
    localparam int PRF_FL_CNT_W = $clog2(PRF_FL_DEPTH) + 1;

    typedef logic [PRF_FL_PTR_W-1:0] t_prf_fl_ptr;

endpackage : common
`default_nettype wire

// File: rtl/prf_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : prf_free_list
//  Description : Physical register free list between retire and rename.
//                Circular buffer of free IDs plus a per-ID free bit-vector
//                used to reject illegal (double-free) reclaims.
//  Ports       : clk, reset (async, active-high)
//                alloc_req_rn0 / alloc_gnt_rn0 / alloc_prf_id_rn0 / empty_rn0
//                    - rename-side pop, zero-cycle head presentation
//                reclaim_prf_rb1 / reclaim_prf_id_rb1
//                    - retire-side push of a reclaimed ID
//                free_count      - number of IDs currently in the list
//                err_overflow    - sticky, reclaim while full
//                err_double_free - sticky, reclaim of an already-free ID
//  Config      : PRF_FL_BYPASS_EN - when defined, an empty list forwards a
//                same-cycle accepted reclaim straight to a pending request.
//  Revision    : 1.0 - initial release
// ============================================================================
module prf_free_list #(
    parameter  int NUM_PRF  = common::NUM_PRF,
    parameter  int NUM_ARCH = common::NUM_ARCH,
    localparam int ID_W     = $clog2(NUM_PRF),
    localparam int DEPTH    = NUM_PRF - NUM_ARCH,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_req_rn0,
    output logic            alloc_gnt_rn0,
    output logic [ID_W-1:0] alloc_prf_id_rn0,
    output logic            empty_rn0,
    input  logic            reclaim_prf_rb1,
    input  logic [ID_W-1:0] reclaim_prf_id_rb1,
    output logic [CNT_W-1:0] free_count,
    output logic            err_overflow,
    output logic            err_double_free
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ID_W-1:0]    entry_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NUM_PRF-1:0] free_vec_q, free_vec_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_dbl_q, err_dbl_d;

    logic               w_empty;
    logic               w_full;
    logic [ID_W-1:0]    w_head;
    logic               w_id_free;
    logic               w_accept;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push;

    assign w_empty   = (rd_ptr_q == wr_ptr_q);
    assign w_full    = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                       (rd_ptr_q[PTR_W-1]   != wr_ptr_q[PTR_W-1]);
    assign w_head    = entry_q[rd_ptr_q[IDX_W-1:0]];
    assign w_id_free = free_vec_q[reclaim_prf_id_rb1];

    // Full and free-ness are judged on current state only, so a grant in the
    // same cycle never makes room for a reclaim that arrives while full.
    assign w_accept  = reclaim_prf_rb1 & ~w_full & ~w_id_free;

`ifdef PRF_FL_BYPASS_EN
    // Reclaimed ID goes straight to rename; it never enters the buffer, so
    // pointers, free_vec and count all stay put.
    assign w_bypass  = w_accept & alloc_req_rn0 & w_empty;
`else
    assign w_bypass  = 1'b0;
`endif

    assign w_pop     = alloc_req_rn0 & ~w_empty;
    assign w_push    = w_accept & ~w_bypass;

    assign alloc_gnt_rn0    = w_pop | w_bypass;
    assign alloc_prf_id_rn0 = w_bypass ? reclaim_prf_id_rb1 : w_head;
    assign empty_rn0        = w_empty;
    assign free_count       = count_q;
    assign err_overflow     = err_ovf_q;
    assign err_double_free  = err_dbl_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(w_pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(w_push);
        count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        err_ovf_d  = err_ovf_q | (reclaim_prf_rb1 & w_full);
        err_dbl_d  = err_dbl_q | (reclaim_prf_rb1 & w_id_free);
        free_vec_d = free_vec_q;
        // The head is free and an accepted reclaim ID is not, so these two
        // updates never target the same bit.
        if (w_pop) begin
            free_vec_d[w_head] = 1'b0;
        end
        if (w_push) begin
            free_vec_d[reclaim_prf_id_rb1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            // Same index, opposite wrap bit: list starts full.
            wr_ptr_q  <= {1'b1, {IDX_W{1'b0}}};
            count_q   <= CNT_W'(DEPTH);
            err_ovf_q <= 1'b0;
            err_dbl_q <= 1'b0;
            for (int i = 0; i < NUM_PRF; i++) begin
                free_vec_q[i] <= (i >= NUM_ARCH);
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_ovf_q  <= err_ovf_d;
            err_dbl_q  <= err_dbl_d;
            free_vec_q <= free_vec_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= ID_W'(NUM_ARCH + i);
            end
        end else if (w_push) begin
            entry_q[wr_ptr_q[IDX_W-1:0]] <= reclaim_prf_id_rb1;
        end
    end

endmodule : prf_free_list
`default_nettype wire
